mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (used as address), the rs2 forward (store data), the destination register and control.
- Performs RV32I loads and stores over a valid/ready data-memory interface, sign- or zero-extends load data, and presents one writeback result per accepted instruction.
- Non-memory instructions pass through with one cycle of latency. Holds `ex_ready` low while a memory access is outstanding.

Parameters:
TIMEOUT, 64, max cycles in WAIT_RSP before the access is aborted with `access_err`; 0 disables the watchdog
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  execute stage presents an instruction
ex_ready  output  1  stage can accept; high only in IDLE
mem_read  input  1  instruction is a load
mem_write  input  1  instruction is a store
funct3  input  3  RV32I width/sign field
alu_result  input  32  effective address, or the result for non-memory instructions
rs2_data  input  32  store data
rd_addr  input  5  destination register
reg_write_in  input  1  instruction writes rd
dmem_req_valid  output  1  memory request valid
dmem_req_ready  input  1  memory accepts request
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_we  output  1  1 = store
dmem_wstrb  output  4  byte enables (0000 on loads)
dmem_wdata  output  32  lane-replicated store data
dmem_rsp_valid  input  1  response/ack; one per accepted request
dmem_rdata  input  32  read word
wb_valid  output  1  one-cycle pulse: writeback fields valid
wb_reg_write  output  1  write rd this pulse
wb_rd_addr  output  5  destination register
wb_data  output  32  load result or pass-through ALU result
access_err  output  1  pulses with wb_valid on misalign, bad funct3, read&write both set, or timeout

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE.
  - Outputs return to zero: all `dmem_*` outputs, all `wb_*` outputs, `access_err`.
  - `ex_ready` = 1 from the first cycle after reset release.
- FSM states: IDLE, REQ, WAIT_RSP.
- Accept occurs on `ex_valid & ex_ready`.
- IDLE, accept of a non-memory instruction:
  - Next cycle: `wb_valid` = 1, `wb_data` = `alu_result`, `wb_reg_write` = `reg_write_in`, `wb_rd_addr` = `rd_addr`.
  - State stays IDLE. Back-to-back throughput is one per cycle.
- IDLE, accept of a legal memory instruction:
  - Latch the request fields and go to REQ.
  - `dmem_req_valid` asserts the next cycle.
- REQ:
  - `dmem_req_valid` and all request fields are held stable until `dmem_req_ready`.
  - On the handshake, go to WAIT_RSP and clear the watchdog.
- WAIT_RSP:
  - On `dmem_rsp_valid`: the next cycle pulses `wb_valid`, and state returns to IDLE.
  - `wb_reg_write` = latched `reg_write_in` for loads, 0 for stores.
  - Watchdog increments each cycle. If it reaches TIMEOUT, go to IDLE and pulse `wb_valid` + `access_err` with `wb_reg_write` = 0.
- `dmem_rsp_valid` is ignored outside WAIT_RSP, including stale responses after a reset or timeout.
- Illegal accept, detected in IDLE:
  - Illegal means any of: `mem_read & mem_write`; misalignment (half with addr[0]=1, word with addr[1:0]≠0); load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - Response: no memory request. The next cycle pulses `wb_valid` + `access_err`, `wb_reg_write` = 0.
- Load extension (lane = addr[1:0]):
  - LB (0): byte sign-extended.
  - LBU (4): byte zero-extended.
  - LH (1): half at addr[1] sign-extended.
  - LHU (5): half zero-extended.
  - LW (2): full word.
- Store formatting:
  - SB: `wstrb` = 0001<<lane; `wdata` = {4{rs2[7:0]}}.
  - SH: `wstrb` = 0011 or 1100; `wdata` = {2{rs2[15:0]}}.
  - SW: `wstrb` = 1111; `wdata` = rs2.
- `wb_valid` and `access_err` are single-cycle pulses. `wb_data` holds its value until the next pulse.
- Reset mid-access drops the outstanding request immediately; no writeback is produced for it.

Test Plan:
- Load sign handling: LB at addr 0x103, rdata=0x80FF_1234 → `dmem_addr`=0x100, `wb_data`=0xFFFF_FF80, `wb_reg_write`=1; same with LBU → 0x0000_0080.
- SH rs2=0x0000_BEEF at addr 0x202, `dmem_req_ready` low for 3 cycles → request held stable; `wstrb`=1100, `wdata`=0xBEEF_BEEF; on ack, `wb_valid` pulse with `wb_reg_write`=0.
- Three back-to-back ALU ops (results 1, 2, 3) → `wb_valid` on three consecutive cycles with `wb_data` 1, 2, 3 and `ex_ready` held at 1.
- Illegal accepts: LW at 0x006, then SB with `mem_read`=`mem_write`=1 → no `dmem_req_valid` for either; each gives `access_err`+`wb_valid` one cycle after accept, `wb_reg_write`=0.
- TIMEOUT=4, no response → at cycle 4 of WAIT_RSP, `access_err`; a late `dmem_rsp_valid` afterwards is ignored and produces no `wb_valid`.
- Assert `rst_n` low during REQ → `dmem_req_valid`=0 asynchronously; after release `ex_ready`=1 and no stray `wb_valid`.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: loads/stores over a valid/ready data-memory port
// Non-memory ops pass through in one cycle; memory ops stall the execute stage until the access completes.
module mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write_in,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        access_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    localparam bit               WDOG_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] wdog;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_lane;
    logic             lat_load;
    logic             lat_reg_write;
    logic [4:0]       lat_rd;
    logic [31:0]      lat_addr;

    logic        is_mem;
    logic        illegal;
    logic [1:0]  lane;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign ex_ready = (state == IDLE);
    assign is_mem   = mem_read | mem_write;
    assign lane     = alu_result[1:0];

    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                3'd0, 3'd4: illegal = 1'b0;
                3'd1, 3'd5: illegal = lane[0];
                3'd2:       illegal = (lane != 2'b00);
                default:    illegal = 1'b1;
            endcase
        end else if (mem_write) begin
            case (funct3)
                3'd0:    illegal = 1'b0;
                3'd1:    illegal = lane[0];
                3'd2:    illegal = (lane != 2'b00);
                default: illegal = 1'b1;
            endcase
        end
    end

    // Store data is replicated across all lanes so the strobe alone selects the bytes written.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = rs2_data;
        case (funct3[1:0])
            2'd0: begin
                st_wstrb = 4'b0001 << lane;
                st_wdata = {4{rs2_data[7:0]}};
            end
            2'd1: begin
                st_wstrb = lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = rs2_data;
            end
        endcase
    end

    assign rd_shift = dmem_rdata >> {lat_lane, 3'b000};
    assign rd_half  = lat_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (lat_funct3)
            3'd0:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd4:    load_data = {24'd0, rd_shift[7:0]};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wdog           <= '0;
            lat_funct3     <= 3'd0;
            lat_lane       <= 2'd0;
            lat_load       <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_rd         <= 5'd0;
            lat_addr       <= 32'd0;
            dmem_req_valid <= 1'b0;
            dmem_addr      <= 32'd0;
            dmem_we        <= 1'b0;
            dmem_wstrb     <= 4'd0;
            dmem_wdata     <= 32'd0;
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_rd_addr     <= 5'd0;
            wb_data        <= 32'd0;
            access_err     <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= alu_result;
                            wb_reg_write <= reg_write_in;
                            wb_rd_addr   <= rd_addr;
                        end else if (illegal) begin
                            wb_valid     <= 1'b1;
                            access_err   <= 1'b1;
                            wb_data      <= alu_result;
                            wb_reg_write <= 1'b0;
                            wb_rd_addr   <= rd_addr;
                        end else begin
                            lat_funct3     <= funct3;
                            lat_lane       <= lane;
                            lat_load       <= mem_read;
                            lat_reg_write  <= reg_write_in;
                            lat_rd         <= rd_addr;
                            lat_addr       <= alu_result;
                            dmem_req_valid <= 1'b1;
                            dmem_addr      <= {alu_result[31:2], 2'b00};
                            dmem_we        <= mem_write;
                            dmem_wstrb     <= mem_write ? st_wstrb : 4'b0000;
                            dmem_wdata     <= mem_write ? st_wdata : 32'd0;
                            state          <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        wdog           <= '0;
                        state          <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= lat_load & lat_reg_write;
                        wb_rd_addr   <= lat_rd;
                        wb_data      <= lat_load ? load_data : lat_addr;
                        state        <= IDLE;
                    end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
                        // Abort reports the faulting address; a late response lands in IDLE and is dropped.
                        wb_valid     <= 1'b1;
                        access_err   <= 1'b1;
                        wb_reg_write <= 1'b0;
                        wb_rd_addr   <= lat_rd;
                        wb_data      <= lat_addr;
                        state        <= IDLE;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
